// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer and its signature compactor.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Deepest CUT response pipeline the capture delay line supports.
  localparam int LAT_MAX = 3;

  // MISR feedback taps, counted down from the MSB: sig[W-1] ^ sig[W-2].
  localparam int MISR_TAP_HI = 1;
  localparam int MISR_TAP_LO = 2;

endpackage

// File: rtl/bist_controller_misr.sv
// Multiple-input signature register: shifts left with XOR feedback from the two
// top bits and folds in the parallel input on every enabled cycle.
module misr
  import bist_pkg::*;
#(
  parameter int RESP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] d,
  output logic [RESP_W-1:0] sig
);

  logic [RESP_W-1:0] sig_q;
  logic [RESP_W-1:0] sig_d;

  function automatic logic [RESP_W-1:0] misr_next(input logic [RESP_W-1:0] s,
                                                   input logic [RESP_W-1:0] din);
    misr_next = {s[RESP_W-2:0], s[RESP_W-MISR_TAP_HI] ^ s[RESP_W-MISR_TAP_LO]} ^ din;
  endfunction

  // Clear wins over compaction so a new run always starts from zero.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_next(sig_q, d);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the pattern LFSR, runs NPAT patterns, compacts the CUT
// responses in a MISR and reports pass/fail through a start/busy/done handshake.
module bist_controller
  import bist_pkg::*;
#(
  parameter int                NBIT   = 4,
  parameter int                NPAT   = 15,
  parameter int                RESP_W = 4,
  parameter int                LAT    = 0,
  parameter logic [RESP_W-1:0] GOLDEN = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [RESP_W-1:0]          cut_resp,
  output logic                       lfsr_rst,
  output logic                       lfsr_scan_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [RESP_W-1:0]          signature,
  output logic [$clog2(NPAT+1)-1:0]  pat_cnt
);

  localparam int CNT_W    = $clog2(NPAT + 1);
  // An LFSR of NBIT bits has only 2^NBIT-1 distinct patterns before repeating.
  localparam int MAX_PAT  = (1 << NBIT) - 1;
  localparam int NPAT_EFF = (NPAT > MAX_PAT) ? MAX_PAT : NPAT;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         drain_q, drain_d;
  logic               clr_s;
  logic               run_s;
  logic               cap_s;
  logic               abort_s;
  logic [RESP_W-1:0]  sig_s;

  assign run_s   = (state_q == ST_RUN);
  assign abort_s = abort && (state_q inside {ST_SEED, ST_RUN, ST_DRAIN, ST_CHECK});

  // Next-state and registered-output decode; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    clr_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SEED;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          clr_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_SEED: state_d = ST_RUN;
      ST_RUN: begin
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        drain_d = 2'd0;
        if (cnt_q == CNT_W'(NPAT_EFF - 1)) begin
          state_d = (LAT > 0) ? ST_DRAIN : ST_CHECK;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(LAT - 1)) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CHECK: begin
        pass_d  = (sig_s == GOLDEN);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_s) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Capture enable trails the RUN cycles by the CUT latency.
  if (LAT == 0) begin : g_nodelay
    assign cap_s = run_s;
  end else begin : g_delay
    logic [LAT-1:0] vld_q;
    // Valid delay line, flushed on abort so no stale capture leaks into IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else if (abort_s) begin
        vld_q <= '0;
      end else begin
        vld_q <= (vld_q << 1) | LAT'(run_s);
      end
    end
    assign cap_s = vld_q[LAT-1];
  end

  misr #(.RESP_W(RESP_W)) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .en   (cap_s && !abort_s),
    .d    (cut_resp),
    .sig  (sig_s)
  );

  assign lfsr_rst     = (state_q != ST_RUN);
  assign lfsr_scan_in = 1'b0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_s;
  assign pat_cnt      = cnt_q;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: three configurations driven with
// directed and random responses, checked edge by edge against a reference model.
module tb_bist_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_v [3];
  logic       abort_v [3];
  logic [3:0] cut_v   [3];
  logic       lrst_v  [3];
  logic       scan_v  [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [3:0] sig_v   [3];
  logic [3:0] pat_v   [3];
  logic [1:0] pc_a;
  logic [3:0] pc_b;
  logic [0:0] pc_c;
  logic [3:0] plan    [0:31];

  int checks = 0;
  int errors = 0;

  assign pat_v[0] = {2'b00, pc_a};
  assign pat_v[1] = pc_b;
  assign pat_v[2] = {3'b000, pc_c};

  // id 0: NPAT=2 LAT=0 GOLDEN=8
  bist_controller #(.NBIT(4), .NPAT(2), .RESP_W(4), .LAT(0), .GOLDEN(4'h8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .cut_resp(cut_v[0]),
    .lfsr_rst(lrst_v[0]), .lfsr_scan_in(scan_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .signature(sig_v[0]), .pat_cnt(pc_a));

  // id 1: NPAT=15 LAT=2 GOLDEN=0
  bist_controller #(.NBIT(4), .NPAT(15), .RESP_W(4), .LAT(2), .GOLDEN(4'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .cut_resp(cut_v[1]),
    .lfsr_rst(lrst_v[1]), .lfsr_scan_in(scan_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .signature(sig_v[1]), .pat_cnt(pc_b));

  // id 2: NPAT=1 LAT=0 GOLDEN=5
  bist_controller #(.NBIT(4), .NPAT(1), .RESP_W(4), .LAT(0), .GOLDEN(4'h5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .cut_resp(cut_v[2]),
    .lfsr_rst(lrst_v[2]), .lfsr_scan_in(scan_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .signature(sig_v[2]), .pat_cnt(pc_c));

  function automatic logic [3:0] misr_step(input logic [3:0] s, input logic [3:0] r);
    return {s[2:0], s[3] ^ s[2]} ^ r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int id);
    chk($sformatf("rst busy id%0d", id), {7'd0, busy_v[id]}, 8'd0);
    chk($sformatf("rst done id%0d", id), {7'd0, done_v[id]}, 8'd0);
    chk($sformatf("rst pass id%0d", id), {7'd0, pass_v[id]}, 8'd0);
    chk($sformatf("rst sig id%0d", id), {4'd0, sig_v[id]}, 8'd0);
    chk($sformatf("rst pat id%0d", id), {4'd0, pat_v[id]}, 8'd0);
    chk($sformatf("rst lfsr_rst id%0d", id), {7'd0, lrst_v[id]}, 8'd1);
    chk($sformatf("rst scan id%0d", id), {7'd0, scan_v[id]}, 8'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) plan[i] = 4'($urandom_range(0, 15));
  endtask

  // One run: plan[e] is the response presented before edge e (edge 0 samples start).
  task automatic run(input int id, input int np, input int lat, input logic [3:0] gold,
                     input int abort_e, input int ign_e, input int rst_e);
    logic [3:0] sig;
    int         last;
    int         pexp;
    bit         stop;
    last = np + lat + 2;
    sig  = 4'h0;
    stop = 1'b0;
    @(negedge clk);
    start_v[id] = 1'b1;
    abort_v[id] = (abort_e == 0);
    cut_v[id]   = plan[0];
    for (int e = 0; e <= last && !stop; e++) begin
      @(posedge clk);
      if (e >= 2 + lat && e <= np + 1 + lat && !(abort_e >= 0 && e >= abort_e))
        sig = misr_step(sig, plan[e]);
      #1;
      if (e == abort_e) begin
        chk($sformatf("abort busy e%0d", e), {7'd0, busy_v[id]}, 8'd0);
        chk($sformatf("abort done e%0d", e), {7'd0, done_v[id]}, 8'd0);
        chk($sformatf("abort pass e%0d", e), {7'd0, pass_v[id]}, 8'd0);
        chk($sformatf("abort lfsr_rst e%0d", e), {7'd0, lrst_v[id]}, 8'd1);
        stop = 1'b1;
      end else begin
        pexp = (e == 0) ? 0 : ((e - 1 < np) ? e - 1 : np);
        chk($sformatf("busy id%0d e%0d", id, e), {7'd0, busy_v[id]}, {7'd0, e < last});
        chk($sformatf("done id%0d e%0d", id, e), {7'd0, done_v[id]}, {7'd0, e == last});
        chk($sformatf("pass id%0d e%0d", id, e), {7'd0, pass_v[id]},
            {7'd0, (e == last) && (sig == gold)});
        chk($sformatf("lfsr_rst id%0d e%0d", id, e), {7'd0, lrst_v[id]},
            {7'd0, !(e >= 1 && e <= np)});
        chk($sformatf("pat_cnt id%0d e%0d", id, e), {4'd0, pat_v[id]}, 8'(pexp));
        chk($sformatf("sig id%0d e%0d", id, e), {4'd0, sig_v[id]}, {4'd0, sig});
        chk($sformatf("scan id%0d e%0d", id, e), {7'd0, scan_v[id]}, 8'd0);
        if (e == rst_e) begin
          #2;
          rst_n = 1'b0;
          #1;
          chk_reset(id);
          stop = 1'b1;
        end
      end
      @(negedge clk);
      start_v[id] = (e + 1 == ign_e);
      abort_v[id] = (e + 1 == abort_e);
      cut_v[id]   = plan[e + 1];
    end
    start_v[id] = 1'b0;
    abort_v[id] = 1'b0;
    rst_n       = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    foreach (start_v[i]) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      cut_v[i]   = 4'h0;
    end
    #12;
    for (int i = 0; i < 3; i++) chk_reset(i);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pattern, matching golden.
    for (int i = 0; i < 32; i++) plan[i] = 4'h5;
    run(2, 1, 0, 4'h5, -1, -1, -1);

    // Two patterns: 5,3 -> 8 (pass); back-to-back rerun 5,2 -> 9 (fail).
    fill_random();
    plan[2] = 4'h5;
    plan[3] = 4'h3;
    run(0, 2, 0, 4'h8, -1, -1, -1);
    plan[3] = 4'h2;
    run(0, 2, 0, 4'h8, -1, -1, -1);

    // Long run with latency, responses tied to zero.
    for (int i = 0; i < 32; i++) plan[i] = 4'h0;
    run(1, 15, 2, 4'h0, -1, -1, -1);

    // Random responses with a start pulse while busy.
    fill_random();
    run(1, 15, 2, 4'h0, -1, 5, -1);

    // Abort when pat_cnt reaches 7, then a clean run.
    fill_random();
    run(1, 15, 2, 4'h0, 9, -1, -1);
    fill_random();
    run(1, 15, 2, 4'h0, -1, -1, -1);

    // Asynchronous reset in the middle of DRAIN, then a clean run.
    fill_random();
    run(1, 15, 2, 4'h0, -1, -1, 17);
    fill_random();
    run(1, 15, 2, 4'h0, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
# bist_controller

Built-in self-test sequencer for the scan-capable pattern LFSR. Seeds the LFSR, runs it autonomously for a fixed number of patterns, and compacts the circuit-under-test (CUT) responses in an internal MISR. At the end it compares the signature against a golden value and reports pass/fail through a start/busy/done handshake. It sits between the test-mode top level and the LFSR/CUT pair.

## Interface
- NBIT, 4: LFSR width; must match the driven LFSR.
- NPAT, 15: patterns applied per run; legal range 1..2^NBIT-1.
- RESP_W, 4: CUT response and signature width, ≥2.
- LAT, 0: CUT response latency in cycles; legal range 0..3.
- GOLDEN, 4'h0: expected signature, RESP_W bits.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- abort  in  1  cancel the current run.
- cut_resp  in  RESP_W  CUT response.
- lfsr_rst  out  1  synchronous seed-load to the LFSR (its active-high rst).
- lfsr_scan_in  out  1  LFSR scan_in; constant 0 (autonomous mode).
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  signature == GOLDEN; valid while done=1.
- signature  out  RESP_W  MISR contents.
- pat_cnt  out  $clog2(NPAT+1)  patterns applied so far.

## Operation
- Reset values: busy=0, done=0, pass=0, signature=0, pat_cnt=0, lfsr_rst=1, lfsr_scan_in=0, state=IDLE.
- IDLE
  - lfsr_rst=1.
  - start=1 → SEED.
- SEED (1 cycle)
  - lfsr_rst=1, so the LFSR loads its seed at the closing edge.
  - Clears signature, pat_cnt, pass and done.
  - busy=1.
  - → RUN.
- RUN
  - lfsr_rst=0; the LFSR advances every cycle.
  - pat_cnt increments per cycle.
  - After NPAT cycles (pat_cnt==NPAT): → DRAIN if LAT>0, else → CHECK.
- DRAIN (LAT cycles)
  - lfsr_rst=1.
  - Collects the last LAT responses still in flight.
- CHECK (1 cycle)
  - Registers pass = (signature==GOLDEN).
  - → DONE.
- DONE
  - done=1, busy=0, lfsr_rst=1.
  - start=1 → SEED, which clears done and pass.
- Capture enable: a valid bit set in each RUN cycle, delayed by a LAT-deep shift register. The MISR updates exactly NPAT times per run, never in other cycles.
- MISR update: signature ← {signature[RESP_W-2:0], signature[RESP_W-1]^signature[RESP_W-2]} ^ cut_resp.
- abort=1 in SEED, RUN, DRAIN or CHECK → IDLE next edge.
  - busy=0, done stays 0, pass=0.
  - Capture shift register is flushed.
  - abort takes priority over every other transition.
  - abort in IDLE or DONE has no effect.
- start while busy=1 is ignored.
- rst_n low at any time returns everything to reset values immediately, including mid-run; no partial result survives.

## Timing
- The edge that samples start is edge 0.
- Pattern k (k=0..NPAT-1) is on the LFSR outputs during the cycle after edge k+1.
- With LAT=L, the response to pattern k is captured at edge k+2+L.
- done and pass rise at edge NPAT+LAT+2.
- busy is high from edge 0 through edge NPAT+LAT+1 and falls at edge NPAT+LAT+2.
- Back-to-back runs: start held high in DONE reaches SEED one cycle later; there are no dead cycles beyond DONE.
- All outputs are registered except lfsr_scan_in (constant) and lfsr_rst, which is decoded from the state register.

## Structure
- Shared package bist_pkg holds:
  - the state enum (IDLE, SEED, RUN, DRAIN, CHECK, DONE);
  - the MISR feedback tap constants;
  - the LAT upper bound (3).
- The MISR is a separate sub-module, misr (parameters RESP_W; ports clk, rst_n, clr, en, d, sig), so the same compactor can be reused on scan_out chains.

## Test plan
- NPAT=1, LAT=0, GOLDEN=4'h5; start, cut_resp=4'h5 → signature=4'h5, pass=1, done at edge 3.
- NPAT=2, LAT=0, GOLDEN=4'h8; responses 4'h5 then 4'h3 → signature 4'h5 then 4'hB^4'h3=4'h8, pass=1; rerun with 4'h5, 4'h2 → 4'h9, pass=0.
- NPAT=15, LAT=2, cut_resp tied 0, GOLDEN=0:
  - lfsr_rst low for exactly 15 cycles;
  - exactly 15 MISR updates;
  - done at edge 19; pass=1; pat_cnt=15.
- Abort in RUN at pat_cnt=7:
  - IDLE next edge, busy=0, done=0;
  - a following start completes normally with the correct signature.
- rst_n pulsed low mid-DRAIN → all outputs at reset values immediately (asynchronous); start while busy → ignored, run timing unchanged.
